ex_muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Accepts one MUL/DIV/REM op

---
 rtl/rv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 34 +++
 rtl/ex_muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// RV32 decode constants and shared types for the EX-stage M-extension sequencer.
package rv_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    MD_MULT   = 1'b0,
    MD_DIVIDE = 1'b1
  } md_mode_t;

  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier / restoring divider.
// Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
module muldiv_step
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  md_mode_t          mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   add_sum;
  logic [2*XLEN:0] shifted;
  logic [XLEN:0]   trial;

  assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
  assign shifted = {acc, 1'b0};
  // Shifted remainder can reach XLEN+1 bits before the trial subtract.
  assign trial   = shifted[2*XLEN:XLEN] - {1'b0, opnd};

  always_comb begin
    acc_next = acc;
    if (mode == MD_MULT) begin
      if (acc[0]) acc_next = {add_sum, acc[XLEN-1:1]};
      else        acc_next = {1'b0, acc[2*XLEN-1:1]};
    end else begin
      if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
      else              acc_next = shifted[2*XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: XLEN steps on operand magnitudes,
// sign fix-up on the DONE cycle, pipeline stall while busy.
module ex_muldiv_seq
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] Read1,
  input  logic [XLEN-1:0] Read2,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ALL_ONES  = '1;
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [2:0]        func3_reg;
  logic [4:0]        rd_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd_reg;
  logic              a_neg_reg, b_neg_reg;
  logic              special_reg;
  logic [XLEN-1:0]   special_val_reg;

  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_val;

  assign accept   = (state_reg == MD_IDLE) && start && !flush;
  assign a_neg    = f3_a_signed(func3) && Read1[XLEN-1];
  assign b_neg    = f3_b_signed(func3) && Read2[XLEN-1];
  assign a_mag    = a_neg ? -Read1 : Read1;
  assign b_mag    = b_neg ? -Read2 : Read2;
  assign div_zero = func3[2] && (Read2 == '0);
  // Only signed DIV/REM (func3[0]==0) can overflow.
  assign div_ovf  = func3[2] && !func3[0] && (Read1 == MOST_NEG) && (Read2 == ALL_ONES);

  always_comb begin
    special_val = '0;
    if (div_zero)     special_val = func3[1] ? Read1 : ALL_ONES;
    else if (div_ovf) special_val = func3[1] ? '0 : MOST_NEG;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= MD_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    stall        = 1'b0;
    result_valid = 1'b0;
    unique case (state_reg)
      MD_IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = (div_zero || div_ovf) ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        stall = 1'b1;
        if (count_reg == LAST_STEP) state_next = MD_DONE;
      end
      MD_DONE: begin
        result_valid = 1'b1;
        state_next   = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
    if (flush) begin
      state_next   = MD_IDLE;
      stall        = 1'b0;
      result_valid = 1'b0;
    end
    // Keep stall low while reset is held even if EX still presents start.
    if (!rst) stall = 1'b0;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (func3_reg[2] ? MD_DIVIDE : MD_MULT),
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg       <= '0;
      func3_reg       <= '0;
      rd_reg          <= '0;
      acc_reg         <= '0;
      opnd_reg        <= '0;
      a_neg_reg       <= 1'b0;
      b_neg_reg       <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= '0;
    end else if (accept) begin
      count_reg       <= '0;
      func3_reg       <= func3;
      rd_reg          <= rd;
      acc_reg         <= {{XLEN{1'b0}}, a_mag};
      opnd_reg        <= b_mag;
      a_neg_reg       <= a_neg;
      b_neg_reg       <= b_neg;
      special_reg     <= div_zero || div_ovf;
      special_val_reg <= special_val;
    end else if (state_reg == MD_CALC) begin
      count_reg <= count_reg + 1'b1;
      acc_reg   <= acc_next;
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem;

  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -acc_reg : acc_reg;
  assign quo      = acc_reg[XLEN-1:0];
  assign rem      = acc_reg[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    if (result_valid) begin
      if (special_reg) begin
        result = special_val_reg;
      end else begin
        case (func3_reg)
          F3_MUL:                        result = prod_fix[XLEN-1:0];
          F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
          F3_DIV, F3_DIVU:               result = (a_neg_reg ^ b_neg_reg) ? -quo : quo;
          F3_REM, F3_REMU:               result = a_neg_reg ? -rem : rem;
          default:                       result = '0;
        endcase
      end
    end
  end

  assign rd_out = rd_reg;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: scoreboarded results, latency, stall, flush and reset abort.
module tb_ex_muldiv_seq;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] read1 = 32'd0;
  logic [31:0] read2 = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        stall, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .func3        (func3),
    .Read1        (read1),
    .Read2        (read2),
    .rd           (rd),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .rd_out       (rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_rd_out"}, 32'(rd_out), 32'd0);
  endtask

  // Caller is just past a rising edge; the op is presented for exactly one cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] expv, input int lat);
    exp_t e, got;
    bit   seen;
    int   cyc;
    e.tag = tag; e.res = expv; e.rd = r; e.lat = lat;
    sb.push_back(e);
    start = 1'b1; func3 = f3; read1 = a; read2 = b; rd = r;
    @(negedge clk);
    chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; read1 = $urandom; read2 = $urandom; rd = ~r;
    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        seen = 1'b1;
        cyc  = c;
      end else begin
        chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
      end
    end
    chk({tag, "_timeout"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk({got.tag, "_latency"}, 32'(cyc), 32'(got.lat));
        chk({got.tag, "_result"}, result, got.res);
        chk({got.tag, "_rd_out"}, 32'(rd_out), 32'(got.rd));
        chk({got.tag, "_stall_done"}, 32'(stall), 32'd0);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held, EX presenting an op: everything must stay quiet.
    #12;
    start = 1'b1; func3 = F3_MUL; read1 = 32'd3; read2 = 32'd3; rd = 5'd9;
    #1;
    chk_idle_outputs("reset");
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("mul_neg",     F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
    run_op("mulhu",       F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
    run_op("mulh",        F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 33);
    run_op("mulhsu",      F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
    run_op("div_neg",     F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
    run_op("rem_neg",     F3_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run_op("divu",        F3_DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       33);
    run_op("remu",        F3_REMU,   32'd100,      32'd7,        5'd11, 32'd2,        33);
    run_op("divu_big",    F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        33);
    run_op("div_by_zero", F3_DIV,    32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
    run_op("remu_by_zero",F3_REMU,   32'd5,        32'd0,        5'd14, 32'd5,        1);
    run_op("div_ovf",     F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run_op("rem_ovf",     F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);

    // Flush in CALC cycle 10: no result, stall drops at once, new op accepted next cycle.
    start = 1'b1; func3 = F3_MUL; read1 = 32'd5; read2 = 32'd6; rd = 5'd17;
    @(negedge clk);
    chk("flush_op_stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("flush_op_stall_busy", 32'(stall), 32'd1);
      chk("flush_op_no_valid", 32'(result_valid), 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    chk("flush_stall_drop", 32'(stall), 32'd0);
    @(negedge clk);
    chk("flush_no_valid", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 5'd18, 32'd12, 33);

    // Asynchronous reset in CALC cycle 15, between clock edges.
    start = 1'b1; func3 = F3_MUL; read1 = 32'd11; read2 = 32'd13; rd = 5'd19;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
    end
    #3;
    rst = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    chk("reset_hold_valid", 32'(result_valid), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("divu_after_reset", F3_DIVU, 32'd9, 32'd3, 5'd20, 32'd3, 33);
    run_op("mul_back_to_back", F3_MUL,  32'd2, 32'd2, 5'd21, 32'd4, 33);

    @(negedge clk);
    chk("final_idle_valid", 32'(result_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
